acf_frame_controller: RTL

- Sequencer for the autocorrelation-sum generator: gates the generator's enable from a ready/valid sample stream and counts block boundaries.
- Captures each LAGS+1-word ACF burst into a double-buffered coefficient bank.
- Presents the banked coefficients to the downstream LPC solver via a ready/valid read stream.
- Provides a flush sequence that zero-pads and drains a final partial block.

---
 rtl/acf_frame_controller.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/acf_frame_controller.sv
// acf_frame_controller: sequencer between a sample stream, the autocorrelation
// sum generator and the downstream LPC solver. Gates the generator enable,
// tracks block boundaries, banks each ACF burst into one of two coefficient
// banks and streams banked words out over a ready/valid interface. A flush
// request zero-pads the current block until its burst has been banked.
`timescale 1ns/1ps
module acf_frame_controller #(
  parameter int LAGS       = 12,
  parameter int BLOCK_SIZE = 4096,
  parameter int ACF_W      = 43
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [15:0]      iSample,
  input  logic             iSampleValid,
  output logic             oSampleReady,
  input  logic             iFlush,
  output logic             oFlushDone,
  output logic             oAcfEnable,
  output logic [15:0]      oAcfSample,
  input  logic [ACF_W-1:0] iAcf,
  input  logic             iAcfValid,
  output logic [ACF_W-1:0] oCoef,
  output logic [3:0]       oCoefIndex,
  output logic             oCoefLast,
  output logic             oCoefValid,
  input  logic             iCoefReady
);

  localparam int IDX_W = 4;
  localparam int CNT_W = $clog2(BLOCK_SIZE + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LAGS);
  localparam logic [CNT_W-1:0] BLOCK_LAST = CNT_W'(BLOCK_SIZE);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_st_e;
  typedef enum logic {S_STREAM, S_FLUSH} state_e;

  state_e          state_q, state_d;
  bank_st_e        bank_st_q [2];
  bank_st_e        bank_st_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] cidx_q, cidx_d;
  logic [ACF_W-1:0] bank_q [2][LAGS+1];

  logic [ACF_W-1:0] coef_q, coef_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             flush_done_q, flush_done_d;

  logic             wr_ok;
  logic             acf_en;
  logic             sample_ready;
  logic [15:0]      acf_sample;
  logic             cap;
  logic             cap_last;
  logic [IDX_W-1:0] rd_idx_nxt;

  // The generator may only run while the write bank can still take a burst.
  assign wr_ok    = (bank_st_q[wr_ptr_q] == B_EMPTY) || (bank_st_q[wr_ptr_q] == B_FILLING);
  assign cap      = acf_en && iAcfValid;
  assign cap_last = cap && (cidx_q == LAST_IDX);
  assign rd_idx_nxt = rd_idx_q + IDX_W'(1);

  assign oSampleReady = sample_ready;
  assign oAcfEnable   = acf_en;
  assign oAcfSample   = acf_sample;
  assign oCoef        = coef_q;
  assign oCoefIndex   = rd_idx_q;
  assign oCoefLast    = last_q;
  assign oCoefValid   = vld_q;
  assign oFlushDone   = flush_done_q;

  // FSM state register
  always_ff @(posedge iClock) begin
    if (iReset) state_q <= S_STREAM;
    else        state_q <= state_d;
  end

  // FSM next state; a flush with nothing accumulated (after this cycle's
  // sample and capture) completes immediately without padding.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      S_STREAM: begin
        if (iFlush) begin
          if ((cnt_d != '0) || (cidx_d != '0)) state_d = S_FLUSH;
          else                                 flush_done_d = 1'b1;
        end
      end
      S_FLUSH: begin
        if (cap_last) begin
          state_d      = S_STREAM;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = S_STREAM;
    endcase
  end

  // FSM outputs: generator drive and sample handshake, held low in reset
  always_comb begin
    sample_ready = 1'b0;
    acf_en       = 1'b0;
    acf_sample   = '0;
    if (!iReset) begin
      case (state_q)
        S_STREAM: begin
          sample_ready = wr_ok;
          acf_en       = iSampleValid && wr_ok;
          acf_sample   = iSample;
        end
        S_FLUSH: begin
          acf_en = wr_ok;
        end
        default: ;
      endcase
    end
  end

  // Block position and capture index advance on generator enables only
  always_comb begin
    cnt_d  = cnt_q;
    cidx_d = cidx_q;
    if (acf_en) cnt_d = (cnt_q == BLOCK_LAST) ? '0 : cnt_q + CNT_W'(1);
    if (cap)    cidx_d = cap_last ? '0 : cidx_q + IDX_W'(1);
  end

  // Bank bookkeeping and read-side output registers. Write and read sides
  // never touch the same bank in one cycle: the writer only owns EMPTY or
  // FILLING banks, the reader only FULL or READING ones.
  always_comb begin
    bank_st_d[0] = bank_st_q[0];
    bank_st_d[1] = bank_st_q[1];
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    coef_d       = coef_q;
    rd_idx_d     = rd_idx_q;
    vld_d        = vld_q;
    last_d       = last_q;

    if (cap) begin
      if (cidx_q == '0) bank_st_d[wr_ptr_q] = B_FILLING;
      if (cap_last) begin
        bank_st_d[wr_ptr_q] = B_FULL;
        wr_ptr_d            = ~wr_ptr_q;
      end
    end

    if (vld_q && iCoefReady) begin
      if (rd_idx_q == LAST_IDX) begin
        bank_st_d[rd_ptr_q] = B_EMPTY;
        rd_ptr_d            = ~rd_ptr_q;
        rd_idx_d            = '0;
        // Chain straight into the other bank if it is already waiting.
        if (bank_st_q[~rd_ptr_q] == B_FULL) begin
          bank_st_d[~rd_ptr_q] = B_READING;
          coef_d               = bank_q[~rd_ptr_q][0];
          last_d               = (LAGS == 0);
          vld_d                = 1'b1;
        end else begin
          vld_d  = 1'b0;
          last_d = 1'b0;
        end
      end else begin
        rd_idx_d = rd_idx_nxt;
        coef_d   = bank_q[rd_ptr_q][rd_idx_nxt];
        last_d   = (rd_idx_nxt == LAST_IDX);
      end
    end else if (!vld_q && (bank_st_q[rd_ptr_q] == B_FULL)) begin
      bank_st_d[rd_ptr_q] = B_READING;
      rd_idx_d            = '0;
      coef_d              = bank_q[rd_ptr_q][0];
      last_d              = (LAGS == 0);
      vld_d               = 1'b1;
    end
  end

  // Control registers; reset drops any banked or in-flight data
  always_ff @(posedge iClock) begin
    if (iReset) begin
      bank_st_q[0] <= B_EMPTY;
      bank_st_q[1] <= B_EMPTY;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cnt_q        <= '0;
      cidx_q       <= '0;
      coef_q       <= '0;
      rd_idx_q     <= '0;
      vld_q        <= 1'b0;
      last_q       <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      cidx_q       <= cidx_d;
      coef_q       <= coef_d;
      rd_idx_q     <= rd_idx_d;
      vld_q        <= vld_d;
      last_q       <= last_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Coefficient storage; validity is tracked by the bank state, so no reset
  always_ff @(posedge iClock) begin
    if (cap) bank_q[wr_ptr_q][cidx_q] <= iAcf;
  end

endmodule
